clint: RTL and testbench

Core-local interrupt source: the memory-mapped peripheral that generates the 4-bit interrupt request vector consumed by the commit/interrupt arbitration stage.
- Holds the machine timer (mtime/mtimecmp), the software-interrupt bit, a latched external-interrupt pending bit and a debug request.
- Presents exactly one request bit at a time (one-hot or zero), because the consumer decodes only one-hot vectors.
- Sits on the core's peripheral bus next to the RAM and UART.

---
 rtl/clint_pkg.sv | 34 +++
 rtl/clint_timer.sv | 47 ++++
 rtl/clint.sv | 138 +++++++++++++
 tb/tb_clint.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared CLINT definitions: bus base, register offsets, interrupt bit indices
// (matching the commit-stage cause decoding) and the request priority picker.
package clint_pkg;

  localparam logic [31:0] CLINT_BASE = 32'h0000_2000;

  typedef enum logic [7:0] {
    REG_MSIP        = 8'h00,
    REG_MTIMECMP_LO = 8'h04,
    REG_MTIMECMP_HI = 8'h08,
    REG_MTIME_LO    = 8'h0C,
    REG_MTIME_HI    = 8'h10,
    REG_EXT_PEND    = 8'h14,
    REG_IRQ_EN      = 8'h18,
    REG_DBG_REQ     = 8'h1C
  } clint_reg_e;

  localparam int IRQ_SOFT  = 0;
  localparam int IRQ_TIMER = 1;
  localparam int IRQ_EXT   = 2;
  localparam int IRQ_DBG   = 3;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Consumer decodes only one-hot vectors: debug > external > software > timer.
  function automatic logic [3:0] irq_pick(input logic [3:0] raw);
    irq_pick = 4'b0000;
    if (raw[IRQ_DBG])        irq_pick[IRQ_DBG]   = 1'b1;
    else if (raw[IRQ_EXT])   irq_pick[IRQ_EXT]   = 1'b1;
    else if (raw[IRQ_SOFT])  irq_pick[IRQ_SOFT]  = 1'b1;
    else if (raw[IRQ_TIMER]) irq_pick[IRQ_TIMER] = 1'b1;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Machine timer: prescaled 64-bit mtime with independent 32-bit half writes
// and a level compare against mtimecmp.
module clint_timer
  import clint_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  input  logic [63:0] cmp_i,
  output logic [63:0] mtime_o,
  output logic        timer_lvl_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic          tick;

  assign tick = (presc_q == PW'(PRESCALE - 1));

  // A half write overrides the increment for that half only.
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_lo_i) mtime_d[31:0]  = wdata_i;
    if (wr_hi_i) mtime_d[63:32] = wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  assign mtime_o     = mtime_q;
  assign timer_lvl_o = (mtime_q >= cmp_i);

endmodule

// File: rtl/clint.sv
// Core-local interrupt source: bus registers, external-line synchronizer and
// registered one-hot request arbitration around the machine timer.
module clint
  import clint_pkg::*;
#(
  parameter int PRESCALE    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  input  logic        ext_irq_i,
  output logic [3:0]  irq_o,
  output logic [63:0] mtime_o
);

  logic [7:0]             word_addr;
  logic                   wr_en, rd_en;
  logic                   ack_q, ack_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   msip_q, msip_d;
  logic [63:0]            mtimecmp_q, mtimecmp_d;
  logic                   ext_pend_q, ext_pend_d;
  logic [3:0]             irq_en_q, irq_en_d;
  logic                   dbg_req_q, dbg_req_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ext_prev_q;
  logic                   ext_rise;
  logic [3:0]             irq_q, irq_d;
  logic                   timer_lvl;
  logic [63:0]            mtime;
  logic                   wr_mtime_lo, wr_mtime_hi;
  logic                   unused_addr;

  assign word_addr   = {addr_i[7:2], 2'b00};
  assign wr_en       = req_i & we_i;
  assign rd_en       = req_i & ~we_i;
  assign unused_addr = ^addr_i[1:0];
  assign wr_mtime_lo = wr_en && (word_addr == REG_MTIME_LO);
  assign wr_mtime_hi = wr_en && (word_addr == REG_MTIME_HI);

  clint_timer #(
    .PRESCALE(PRESCALE)
  ) u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .wr_lo_i    (wr_mtime_lo),
    .wr_hi_i    (wr_mtime_hi),
    .wdata_i    (wdata_i),
    .cmp_i      (mtimecmp_q),
    .mtime_o    (mtime),
    .timer_lvl_o(timer_lvl)
  );

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], ext_irq_i};
  assign ext_rise = sync_q[SYNC_STAGES-1] & ~ext_prev_q;

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (word_addr)
        REG_MSIP:        rdata_d = {31'd0, msip_q};
        REG_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
        REG_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
        REG_MTIME_LO:    rdata_d = mtime[31:0];
        REG_MTIME_HI:    rdata_d = mtime[63:32];
        REG_EXT_PEND:    rdata_d = {31'd0, ext_pend_q};
        REG_IRQ_EN:      rdata_d = {28'd0, irq_en_q};
        REG_DBG_REQ:     rdata_d = {31'd0, dbg_req_q};
        default:         rdata_d = '0;
      endcase
    end
  end

  // A new synchronized edge beats a same-cycle completion clear; for the
  // debug request the clear bit beats the set bit.
  always_comb begin
    ack_d      = req_i;
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    ext_pend_d = ext_pend_q;
    irq_en_d   = irq_en_q;
    dbg_req_d  = dbg_req_q;
    if (wr_en) begin
      case (word_addr)
        REG_MSIP:        msip_d = wdata_i[0];
        REG_MTIMECMP_LO: mtimecmp_d[31:0] = wdata_i;
        REG_MTIMECMP_HI: mtimecmp_d[63:32] = wdata_i;
        REG_EXT_PEND:    if (wdata_i[0]) ext_pend_d = 1'b0;
        REG_IRQ_EN:      irq_en_d = wdata_i[3:0];
        REG_DBG_REQ: begin
          if (wdata_i[1])      dbg_req_d = 1'b0;
          else if (wdata_i[0]) dbg_req_d = 1'b1;
        end
        default: ;
      endcase
    end
    if (ext_rise) ext_pend_d = 1'b1;
    irq_d = irq_pick({dbg_req_q, ext_pend_q, timer_lvl, msip_q} & irq_en_q);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      msip_q     <= 1'b0;
      mtimecmp_q <= MTIMECMP_RST;
      ext_pend_q <= 1'b0;
      irq_en_q   <= 4'b0000;
      dbg_req_q  <= 1'b0;
      sync_q     <= '0;
      ext_prev_q <= 1'b0;
      irq_q      <= 4'b0000;
    end else begin
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      ext_pend_q <= ext_pend_d;
      irq_en_q   <= irq_en_d;
      dbg_req_q  <= dbg_req_d;
      sync_q     <= sync_d;
      ext_prev_q <= sync_q[SYNC_STAGES-1];
      irq_q      <= irq_d;
    end
  end

  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;
  assign mtime_o = mtime;

endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint: one instance at PRESCALE=1 for the register and
// interrupt paths, one at PRESCALE=3 for mtime wrap and write-vs-increment.
module tb_clint;
  import clint_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, ext0 = 1'b0;
  logic [7:0]  addr0 = '0;
  logic [31:0] wdata0 = '0;
  logic        ack0;
  logic [31:0] rdata0;
  logic [3:0]  irq0;
  logic [63:0] mtime0;
  logic        req1 = 1'b0, we1 = 1'b0, ext1 = 1'b0;
  logic [7:0]  addr1 = '0;
  logic [31:0] wdata1 = '0;
  logic        ack1;
  logic [31:0] rdata1;
  logic [3:0]  irq1;
  logic [63:0] mtime1;

  int          checks = 0;
  int          errors = 0;
  bit          monOn = 1'b0;
  logic        reqSeen0 = 1'b0, reqSeen1 = 1'b0;
  logic [31:0] expQ0[$];
  logic [31:0] expQ1[$];
  logic [31:0] exp0, exp1;
  logic [63:0] prevMtime;
  logic        found;

  always #5 clk = ~clk;

  clint #(.PRESCALE(1), .SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .req_i(req0), .we_i(we0), .addr_i(addr0),
    .wdata_i(wdata0), .ack_o(ack0), .rdata_o(rdata0), .ext_irq_i(ext0),
    .irq_o(irq0), .mtime_o(mtime0)
  );

  clint #(.PRESCALE(3), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .rstn(rstn), .req_i(req1), .we_i(we1), .addr_i(addr1),
    .wdata_i(wdata1), .ack_o(ack1), .rdata_o(rdata1), .ext_irq_i(ext1),
    .irq_o(irq1), .mtime_o(mtime1)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one bus access at the next falling edge and queues its expected read data.
  task automatic applyStimulus(input int inst, input logic we, input logic [7:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expRd);
    @(negedge clk);
    if (inst == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
      expQ0.push_back(we ? 32'd0 : expRd);
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
      expQ1.push_back(we ? 32'd0 : expRd);
    end
    @(posedge clk);
    #1;
    req0 = 1'b0; we0 = 1'b0;
    req1 = 1'b0; we1 = 1'b0;
  endtask

  task automatic wr(input int inst, input logic [7:0] addr, input logic [31:0] data);
    applyStimulus(inst, 1'b1, addr, data, 32'd0);
  endtask

  task automatic rd(input int inst, input logic [7:0] addr, input logic [31:0] expRd);
    applyStimulus(inst, 1'b0, addr, 32'd0, expRd);
  endtask

  always @(posedge clk) begin
    reqSeen0 <= req0 & rstn;
    reqSeen1 <= req1 & rstn;
  end

  // Monitor: ack must follow each accepted request by one cycle, read data is
  // popped from the scoreboard on ack and must be zero otherwise.
  always @(negedge clk) begin
    if (monOn) begin
      checkOutput("ack0_timing", {63'd0, ack0}, {63'd0, reqSeen0});
      checkOutput("irq0_onehot", {63'd0, $onehot0(irq0)}, 64'd1);
      if (ack0 === 1'b1) begin
        if (expQ0.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL sb0_underflow: got ack with rdata %h expected no ack", rdata0);
        end else begin
          exp0 = expQ0.pop_front();
          checkOutput("rdata0", {32'd0, rdata0}, {32'd0, exp0});
        end
      end else begin
        checkOutput("rdata0_idle", {32'd0, rdata0}, 64'd0);
      end
      checkOutput("ack1_timing", {63'd0, ack1}, {63'd0, reqSeen1});
      if (ack1 === 1'b1) begin
        if (expQ1.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL sb1_underflow: got ack with rdata %h expected no ack", rdata1);
        end else begin
          exp1 = expQ1.pop_front();
          checkOutput("rdata1", {32'd0, rdata1}, {32'd0, exp1});
        end
      end else begin
        checkOutput("rdata1_idle", {32'd0, rdata1}, 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    $display("[TB] start");
    // Reset with a request landing on a reset edge: no ack may follow.
    @(negedge clk); req0 = 1'b1; addr0 = REG_MSIP;
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    checkOutput("rst_ack", {63'd0, ack0}, 64'd0);
    checkOutput("rst_rdata", {32'd0, rdata0}, 64'd0);
    checkOutput("rst_irq", {60'd0, irq0}, 64'd0);
    checkOutput("rst_mtime", mtime0, 64'd0);
    checkOutput("rst_mtime3", mtime1, 64'd0);
    monOn = 1'b1;

    // First access is sampled on the first active edge, so mtime still reads 0.
    rstn = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = REG_MTIME_LO; expQ0.push_back(32'd0);
    @(posedge clk); #1 req0 = 1'b0;
    rd(0, REG_MSIP, 32'd0);
    rd(0, REG_MTIMECMP_LO, 32'hFFFF_FFFF);
    rd(0, REG_MTIMECMP_HI, 32'hFFFF_FFFF);
    rd(0, REG_MTIME_HI, 32'd0);
    rd(0, REG_EXT_PEND, 32'd0);
    rd(0, REG_IRQ_EN, 32'd0);
    rd(0, REG_DBG_REQ, 32'd0);
    rd(0, 8'h20, 32'd0);
    checkOutput("irq_after_reads", {60'd0, irq0}, 64'd0);

    // Timer compare.
    wr(0, REG_IRQ_EN, 32'h2);
    wr(0, REG_MTIMECMP_HI, 32'd0);
    wr(0, REG_MTIME_LO, 32'd0);
    wr(0, REG_MTIMECMP_LO, 32'd20);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mtime0 == 64'd20) begin found = 1'b1; break; end
    end
    checkOutput("timer_reach20", {63'd0, found}, 64'd1);
    checkOutput("irq_pre_timer", {60'd0, irq0}, 64'd0);
    @(negedge clk);
    checkOutput("irq_timer", {60'd0, irq0}, 64'h2);
    wr(0, REG_MTIMECMP_LO, 32'd100);
    @(negedge clk);
    checkOutput("irq_timer_hold", {60'd0, irq0}, 64'h2);
    @(negedge clk);
    checkOutput("irq_timer_clr", {60'd0, irq0}, 64'd0);

    // Software beats timer; external beats software.
    wr(0, REG_MTIMECMP_LO, 32'd0);
    wr(0, REG_IRQ_EN, 32'hF);
    wr(0, REG_MSIP, 32'h1);
    @(negedge clk);
    checkOutput("irq_timer_only", {60'd0, irq0}, 64'h2);
    @(negedge clk);
    checkOutput("irq_soft", {60'd0, irq0}, 64'h1);
    ext0 = 1'b1;
    @(negedge clk); ext0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("irq_ext_3cyc", {60'd0, irq0}, 64'h1);
    @(negedge clk);
    checkOutput("irq_ext_4cyc", {60'd0, irq0}, 64'h4);
    wr(0, REG_EXT_PEND, 32'h1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("irq_ext_done", {60'd0, irq0}, 64'h1);
    rd(0, REG_EXT_PEND, 32'd0);

    // Held-high line must not re-arm after completion.
    ext0 = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("irq_ext_held", {60'd0, irq0}, 64'h4);
    wr(0, REG_EXT_PEND, 32'h1);
    repeat (3) @(negedge clk);
    checkOutput("irq_held_cleared", {60'd0, irq0}, 64'h1);
    rd(0, REG_EXT_PEND, 32'd0);
    ext0 = 1'b0;
    repeat (4) @(negedge clk);
    // Edge reaches ext_pend on the same edge as the clear write.
    ext0 = 1'b1;
    @(negedge clk); ext0 = 1'b0;
    wr(0, REG_EXT_PEND, 32'h1);
    rd(0, REG_EXT_PEND, 32'h1);

    // Debug request.
    wr(0, REG_DBG_REQ, 32'h1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("irq_dbg", {60'd0, irq0}, 64'h8);
    rd(0, REG_DBG_REQ, 32'h1);
    wr(0, REG_DBG_REQ, 32'h0);
    rd(0, REG_DBG_REQ, 32'h1);
    wr(0, REG_DBG_REQ, 32'h3);
    rd(0, REG_DBG_REQ, 32'h0);
    @(negedge clk);
    checkOutput("irq_dbg_fall", {60'd0, irq0}, 64'h4);

    // Unmapped and sub-word addressing.
    wr(0, 8'h20, 32'hFFFF_FFFF);
    rd(0, 8'h20, 32'd0);
    rd(0, 8'h1B, 32'h0000_000F);

    // PRESCALE=3: align to a tick, then land writes on tick edges.
    wr(1, REG_MTIME_HI, 32'hFFFF_FFFF);
    prevMtime = mtime1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mtime1 !== prevMtime) begin found = 1'b1; break; end
    end
    checkOutput("tick_seen", {63'd0, found}, 64'd1);
    @(negedge clk);
    wr(1, REG_MTIME_LO, 32'hFFFF_FFFF);
    @(negedge clk);
    checkOutput("mtime3_ones", mtime1, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    checkOutput("mtime3_ones_hold", mtime1, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    checkOutput("mtime3_wrap", mtime1, 64'd0);
    @(negedge clk);
    wr(1, REG_MTIME_LO, 32'd5);
    @(negedge clk);
    checkOutput("mtime3_wr_wins", mtime1, 64'd5);
    rd(1, REG_MTIME_LO, 32'd5);
    rd(1, REG_MTIME_HI, 32'd0);

    // Reset arriving with an access in flight drops the ack.
    @(negedge clk);
    rstn = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = REG_MSIP;
    @(posedge clk); #1 req0 = 1'b0;
    @(negedge clk);
    checkOutput("midrst_ack", {63'd0, ack0}, 64'd0);
    checkOutput("midrst_irq", {60'd0, irq0}, 64'd0);
    checkOutput("midrst_mtime", mtime0, 64'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("sb0_drained", 64'(expQ0.size()), 64'd0);
    checkOutput("sb1_drained", 64'(expQ1.size()), 64'd0);
    monOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
